// File: rtl/multiciclo_control_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, ULA op codes,
// mux-select codes, FSM state encoding and the bundled control word.
package multiciclo_control_pkg;

    localparam int STATE_W = 4;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_TYPE = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Branch funct3 codes
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // ula_op codes consumed by ula_control
    localparam logic [2:0] ULA_ADD   = 3'b000;
    localparam logic [2:0] ULA_SUB   = 3'b001;
    localparam logic [2:0] ULA_RTYPE = 3'b010;
    localparam logic [2:0] ULA_ITYPE = 3'b011;
    localparam logic [2:0] ULA_LUI   = 3'b100;

    // Mux-select codes
    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_RS1    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;
    localparam logic [1:0] SRC_A_ZERO   = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_IMM  = 2'b10;

    localparam logic [1:0] PC_SRC_ULA    = 2'b00;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_RST,
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_LUI,
        S_AUIPC,
        S_WB_ALU,
        S_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_TRAP
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       reg_write;
        logic [1:0] mem_to_reg;
        logic [1:0] ula_src_a;
        logic [1:0] ula_src_b;
        logic [2:0] ula_op;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    // Dispatch target out of DECODE; unknown opcodes park the core in TRAP.
    function automatic state_t decode_opcode(input logic [6:0] opcode);
        state_t s;
        case (opcode)
            OP_R_TYPE:          s = S_EXEC_R;
            OP_I_TYPE:          s = S_EXEC_I;
            OP_LOAD, OP_STORE:  s = S_ADDR;
            OP_BRANCH:          s = S_BRANCH;
            OP_JAL:             s = S_JAL;
            OP_JALR:            s = S_JALR;
            OP_LUI:             s = S_LUI;
            OP_AUIPC:           s = S_AUIPC;
            default:            s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/multiciclo_control_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
interface multiciclo_control_if;
    import multiciclo_control_pkg::*;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;

    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] ula_src_a;
    logic [1:0] ula_src_b;
    logic [2:0] ula_op;
    logic       instr_done;
    logic       illegal;

    modport master (
        input  opcode, funct3, zero, lt, ltu, mem_ready,
        output mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, ula_src_a, ula_src_b, ula_op,
               instr_done, illegal
    );

    modport slave (
        output opcode, funct3, zero, lt, ltu, mem_ready,
        input  mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
               reg_write, mem_to_reg, ula_src_a, ula_src_b, ula_op,
               instr_done, illegal
    );

endinterface

// File: rtl/multiciclo_control_branch_cond.sv
// Branch resolution from comparator flags; funct3 010/011 are reserved and flagged.
module multiciclo_control_branch_cond
    import multiciclo_control_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       taken,
    output logic       bad_f3
);

    always_comb begin
        taken  = 1'b0;
        bad_f3 = 1'b0;
        case (funct3)
            F3_BEQ:  taken = zero;
            F3_BNE:  taken = ~zero;
            F3_BLT:  taken = lt;
            F3_BGE:  taken = ~lt;
            F3_BLTU: taken = ltu;
            F3_BGEU: taken = ~ltu;
            default: bad_f3 = 1'b1;
        endcase
    end

endmodule

// File: rtl/multiciclo_control.sv
// Multicycle RV32I control FSM: state register, next-state logic and a state-decoded
// control word (with a few input-qualified strobes on memory and branch cycles).
module multiciclo_control
    import multiciclo_control_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    multiciclo_control_if.master bus
);

    state_t state_reg;
    state_t state_next;
    ctrl_t  ctrl;
    logic   br_taken;
    logic   br_bad_f3;

    multiciclo_control_branch_cond u_branch_cond (
        .funct3 (bus.funct3),
        .zero   (bus.zero),
        .lt     (bus.lt),
        .ltu    (bus.ltu),
        .taken  (br_taken),
        .bad_f3 (br_bad_f3)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_RST;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RST:    state_next = S_FETCH;
            S_FETCH:  if (bus.mem_ready) state_next = S_DECODE;
            S_DECODE: state_next = decode_opcode(bus.opcode);
            S_EXEC_R,
            S_EXEC_I,
            S_LUI,
            S_AUIPC:  state_next = S_WB_ALU;
            S_WB_ALU: state_next = S_FETCH;
            // Loads and stores differ only in opcode bit 5.
            S_ADDR:   state_next = bus.opcode[5] ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: if (bus.mem_ready) state_next = S_MEM_WB;
            S_MEM_WB: state_next = S_FETCH;
            S_MEM_WR: if (bus.mem_ready) state_next = S_FETCH;
            S_BRANCH: state_next = br_bad_f3 ? S_TRAP : S_FETCH;
            S_JAL,
            S_JALR:   state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_TRAP;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state_reg)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.ula_src_a = SRC_A_PC;
                ctrl.ula_src_b = SRC_B_FOUR;
                ctrl.ula_op    = ULA_ADD;
                ctrl.pc_src    = PC_SRC_ULA;
                ctrl.ir_write  = bus.mem_ready;
                ctrl.pc_write  = bus.mem_ready;
            end
            // Precompute the PC-relative target into ALUOut for branches and JAL.
            S_DECODE, S_AUIPC: begin
                ctrl.ula_src_a = SRC_A_OLD_PC;
                ctrl.ula_src_b = SRC_B_IMM;
                ctrl.ula_op    = ULA_ADD;
            end
            S_EXEC_R: begin
                ctrl.ula_src_a = SRC_A_RS1;
                ctrl.ula_src_b = SRC_B_RS2;
                ctrl.ula_op    = ULA_RTYPE;
            end
            S_EXEC_I: begin
                ctrl.ula_src_a = SRC_A_RS1;
                ctrl.ula_src_b = SRC_B_IMM;
                ctrl.ula_op    = ULA_ITYPE;
            end
            S_LUI: begin
                ctrl.ula_src_a = SRC_A_ZERO;
                ctrl.ula_src_b = SRC_B_IMM;
                ctrl.ula_op    = ULA_LUI;
            end
            S_WB_ALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = WB_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            S_ADDR: begin
                ctrl.ula_src_a = SRC_A_RS1;
                ctrl.ula_src_b = SRC_B_IMM;
                ctrl.ula_op    = ULA_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = WB_MDR;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = bus.mem_ready;
            end
            // A reserved funct3 must not retire or redirect; it falls into TRAP.
            S_BRANCH: begin
                ctrl.ula_src_a  = SRC_A_RS1;
                ctrl.ula_src_b  = SRC_B_RS2;
                ctrl.ula_op     = ULA_SUB;
                ctrl.pc_src     = PC_SRC_ALUOUT;
                ctrl.pc_write   = br_taken & ~br_bad_f3;
                ctrl.instr_done = ~br_bad_f3;
            end
            S_JAL: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = WB_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_SRC_ALUOUT;
                ctrl.instr_done = 1'b1;
            end
            // rd takes the pre-edge PC (already PC+4) while the PC loads rs1+imm.
            S_JALR: begin
                ctrl.ula_src_a  = SRC_A_RS1;
                ctrl.ula_src_b  = SRC_B_IMM;
                ctrl.ula_op     = ULA_ADD;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = WB_PC;
                ctrl.pc_write   = 1'b1;
                ctrl.pc_src     = PC_SRC_JALR;
                ctrl.instr_done = 1'b1;
            end
            S_TRAP: begin
                ctrl.illegal = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

    assign bus.mem_read   = ctrl.mem_read;
    assign bus.mem_write  = ctrl.mem_write;
    assign bus.i_or_d     = ctrl.i_or_d;
    assign bus.ir_write   = ctrl.ir_write;
    assign bus.pc_write   = ctrl.pc_write;
    assign bus.pc_src     = ctrl.pc_src;
    assign bus.reg_write  = ctrl.reg_write;
    assign bus.mem_to_reg = ctrl.mem_to_reg;
    assign bus.ula_src_a  = ctrl.ula_src_a;
    assign bus.ula_src_b  = ctrl.ula_src_b;
    assign bus.ula_op     = ctrl.ula_op;
    assign bus.instr_done = ctrl.instr_done;
    assign bus.illegal    = ctrl.illegal;

endmodule
